// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Two-requester (core / debug) arbiter for a single-port data
//            memory. Round-robin on ties, latches the granted request,
//            inserts read-latency wait states and pulses a completion ack.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1      // legal 1..3
) (
    input  logic              clk,
    input  logic              rst_n,
    // core load/store path
    input  logic              i_core_req,
    input  logic              i_core_we,
    input  logic [ADDR_W-1:0] i_core_addr,
    input  logic [DATA_W-1:0] i_core_wdata,
    output logic [DATA_W-1:0] o_core_rdata,
    output logic              o_core_ack,
    output logic              o_core_stall,
    // debug/loader path
    input  logic              i_dbg_req,
    input  logic              i_dbg_we,
    input  logic [ADDR_W-1:0] i_dbg_addr,
    input  logic [DATA_W-1:0] i_dbg_wdata,
    output logic [DATA_W-1:0] o_dbg_rdata,
    output logic              o_dbg_ack,
    // memory side
    output logic              o_dmem_enable,
    output logic              o_dmem_write_enable,
    output logic [ADDR_W-1:0] o_dmem_addr,
    output logic [DATA_W-1:0] o_dmem_wdata,
    input  logic [DATA_W-1:0] i_dmem_rdata
);

    // Wait counter preload: the last WAIT cycle is the one where it reads 0.
    localparam logic [1:0] c_WAIT_INIT = 2'(RD_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_grant_valid;
    logic              w_grant_dbg;

    logic              r_last_dbg;   // 1 = debug port was granted last
    logic              r_gnt_dbg;    // requester owning the access in flight
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [1:0]        r_wait_cnt;
    logic [DATA_W-1:0] r_core_rdata;
    logic [DATA_W-1:0] r_dbg_rdata;

    // State register; reset aborts any access in flight without an ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and round-robin grant decision.
    always_comb begin
        w_state_nxt   = r_state;
        w_grant_valid = 1'b0;
        w_grant_dbg   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_grant_valid = i_core_req | i_dbg_req;
                // On a tie the requester not served last wins.
                if (i_core_req && i_dbg_req) begin
                    w_grant_dbg = ~r_last_dbg;
                end else begin
                    w_grant_dbg = i_dbg_req;
                end
                if (w_grant_valid) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_nxt = r_we ? S_DONE : S_WAIT;
            end
            S_WAIT: begin
                if (r_wait_cnt == 2'd0) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Grant capture, wait counting and per-requester read data holding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_dbg   <= 1'b1;
            r_gnt_dbg    <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wait_cnt   <= 2'd0;
            r_core_rdata <= '0;
            r_dbg_rdata  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_valid) begin
                        r_gnt_dbg  <= w_grant_dbg;
                        r_last_dbg <= w_grant_dbg;
                        r_we       <= w_grant_dbg ? i_dbg_we    : i_core_we;
                        r_addr     <= w_grant_dbg ? i_dbg_addr  : i_core_addr;
                        r_wdata    <= w_grant_dbg ? i_dbg_wdata : i_core_wdata;
                    end
                end
                S_ISSUE: begin
                    r_wait_cnt <= c_WAIT_INIT;
                end
                S_WAIT: begin
                    r_wait_cnt <= r_wait_cnt - 2'd1;
                    if (r_wait_cnt == 2'd0) begin
                        if (r_gnt_dbg) begin
                            r_dbg_rdata <= i_dmem_rdata;
                        end else begin
                            r_core_rdata <= i_dmem_rdata;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Memory strobes and acks decode from registered state only.
    assign o_dmem_enable       = (r_state == S_ISSUE);
    assign o_dmem_write_enable = (r_state == S_ISSUE) & r_we;
    assign o_dmem_addr         = r_addr;
    assign o_dmem_wdata        = r_wdata;

    assign o_core_ack   = (r_state == S_DONE) & ~r_gnt_dbg;
    assign o_dbg_ack    = (r_state == S_DONE) &  r_gnt_dbg;
    assign o_core_rdata = r_core_rdata;
    assign o_dbg_rdata  = r_dbg_rdata;
    assign o_core_stall = i_core_req & ~o_core_ack;

endmodule

`default_nettype wire
